// File: rtl/div_req_sequencer.sv
// Request front-end for the 16/8 non-restoring divider.
// Screens each request for divide-by-zero and quotient overflow, launches the
// divider only for legal requests, and holds the result on a valid/ready port.
// Optional build macro: DIV_TIMEOUT_EN adds a WAIT-state watchdog that answers
// with rsp_err when the divider never reports done.
module div_req_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_dividend,
    input  logic [7:0]  req_divisor,
    output logic        div_start,
    output logic [15:0] div_dividend,
    output logic [7:0]  div_divisor,
    input  logic [7:0]  div_quotient,
    input  logic [7:0]  div_remainder,
    input  logic        div_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_quotient,
    output logic [7:0]  rsp_remainder,
    output logic        rsp_dbz,
    output logic        rsp_ovf,
    output logic        rsp_err
);

    typedef enum logic [2:0] {StIdle, StCheck, StLaunch, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [15:0] dividend_q, dividend_d;
    logic [7:0]  divisor_q, divisor_d;
    logic        start_q, start_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  quot_q, quot_d;
    logic [7:0]  rem_q, rem_d;
    logic        dbz_q, dbz_d;
    logic        ovf_q, ovf_d;
    logic        chk_dbz, chk_ovf;

`ifdef DIV_TIMEOUT_EN
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             err_q, err_d;
    logic             wdog_expired;

    assign wdog_expired = (wdog_q == WdogW'(TIMEOUT_CYCLES));
`else
    // Parameter kept for interface compatibility with the watchdog build.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

    // Quotient fits in 8 bits only when the dividend's high byte is below the divisor.
    assign chk_dbz = (divisor_q == 8'd0);
    assign chk_ovf = !chk_dbz && (dividend_q[15:8] >= divisor_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        start_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
`ifdef DIV_TIMEOUT_EN
        wdog_d      = wdog_q;
        err_d       = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    dividend_d = req_dividend;
                    divisor_d  = req_divisor;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (chk_dbz || chk_ovf) begin
                    quot_d      = 8'hFF;
                    rem_d       = 8'h00;
                    dbz_d       = chk_dbz;
                    ovf_d       = chk_ovf;
`ifdef DIV_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    start_d = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
`ifdef DIV_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (div_done) begin
                    quot_d      = div_quotient;
                    rem_d       = div_remainder;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
`ifdef DIV_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
`ifdef DIV_TIMEOUT_EN
                else if (wdog_expired) begin
                    quot_d      = 8'hFF;
                    rem_d       = 8'h00;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dividend_q  <= 16'd0;
            divisor_q   <= 8'd0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            quot_q      <= 8'd0;
            rem_q       <= 8'd0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
`ifdef DIV_TIMEOUT_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready     = (state_q == StIdle);
    assign div_start     = start_q;
    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_quotient  = quot_q;
    assign rsp_remainder = rem_q;
    assign rsp_dbz       = dbz_q;
    assign rsp_ovf       = ovf_q;
`ifdef DIV_TIMEOUT_EN
    assign rsp_err       = err_q;
`else
    assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_div_req_sequencer.sv
// Self-checking bench for div_req_sequencer with a behavioural divider model.
module tb_div_req_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_dividend;
    logic [7:0]  req_divisor;
    logic        div_start;
    logic [15:0] div_dividend;
    logic [7:0]  div_divisor;
    logic [7:0]  div_quotient;
    logic [7:0]  div_remainder;
    logic        div_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_quotient;
    logic [7:0]  rsp_remainder;
    logic        rsp_dbz;
    logic        rsp_ovf;
    logic        rsp_err;

    int   vectors = 0;
    int   miscompares = 0;
    logic done_en = 1'b1;

    always #5 clk = ~clk;

    div_req_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_done     (div_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_quotient (rsp_quotient),
        .rsp_remainder(rsp_remainder),
        .rsp_dbz      (rsp_dbz),
        .rsp_ovf      (rsp_ovf),
        .rsp_err      (rsp_err)
    );

    // Divider model: done pulse 19 cycles after the start cycle, aborted by reset.
    initial begin : divider_model
        int   ai, bi;
        logic abort;
        div_done      = 1'b0;
        div_quotient  = 8'd0;
        div_remainder = 8'd0;
        forever begin
            @(negedge clk);
            if (div_start === 1'b1) begin
                ai    = int'(div_dividend);
                bi    = int'(div_divisor);
                abort = 1'b0;
                for (int i = 0; i < 19; i++) begin
                    @(posedge clk);
                    #2;
                    if (!rst_n) abort = 1'b1;
                end
                if (!abort && done_en && bi != 0) begin
                    div_quotient  = 8'(ai / bi);
                    div_remainder = 8'(ai % bi);
                    div_done      = 1'b1;
                    @(posedge clk);
                    #2;
                    div_done = 1'b0;
                end
            end
        end
    end

    // Reference: what the front-end should answer for a request, from arithmetic alone.
    function automatic void ref_model(input logic [15:0] dd, input logic [7:0] dv,
                                      output int lat, output logic [7:0] q,
                                      output logic [7:0] r, output logic dbz,
                                      output logic ovf);
        int a, b;
        a = int'(dd);
        b = int'(dv);
        if (b == 0) begin
            lat = 2; q = 8'hFF; r = 8'h00; dbz = 1'b1; ovf = 1'b0;
        end else if (a / b > 255) begin
            lat = 2; q = 8'hFF; r = 8'h00; dbz = 1'b0; ovf = 1'b1;
        end else begin
            lat = 22; q = 8'(a / b); r = 8'(a % b); dbz = 1'b0; ovf = 1'b0;
        end
    endfunction

    // Issue one request, measure latency (cycles after the accept cycle), consume response.
    task automatic run_req(input logic [15:0] dd, input logic [7:0] dv, output int lat,
                           output int starts, output int start_lat, output logic got,
                           output logic [7:0] q, output logic [7:0] r, output logic dbz,
                           output logic ovf, output logic err);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        req_dividend = dd;
        req_divisor  = dv;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat       = 1;
        starts    = 0;
        start_lat = -1;
        while (!rsp_valid && lat < 200) begin
            if (div_start) begin
                starts++;
                start_lat = lat;
            end
            @(posedge clk); #1;
            lat++;
        end
        got = rsp_valid;
        q   = rsp_quotient;
        r   = rsp_remainder;
        dbz = rsp_dbz;
        ovf = rsp_ovf;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if ({div_start, div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_remainder,
             rsp_dbz, rsp_ovf, rsp_err} !== 44'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got start=%b dd=%h dv=%h v=%b q=%h r=%h flags=%b%b%b want all 0",
                     div_start, div_dividend, div_divisor, rsp_valid, rsp_quotient,
                     rsp_remainder, rsp_dbz, rsp_ovf, rsp_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        // Stray done pulse while idle must not produce a response.
        div_done = 1'b1;
        @(posedge clk); #1;
        div_done = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_done: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_normal;
        int lat, starts, slat;
        logic got, dbz, ovf, err;
        logic [7:0] q, r;
        run_req(16'd1000, 8'd7, lat, starts, slat, got, q, r, dbz, ovf, err);
        vectors++;
        if (lat !== 22 || got !== 1'b1) begin
            miscompares++;
            $display("FAIL normal_latency: got %0d (valid=%b) want 22", lat, got);
        end
        vectors++;
        if (starts !== 1 || slat !== 2) begin
            miscompares++;
            $display("FAIL normal_start: got %0d pulses at %0d want 1 at 2", starts, slat);
        end
        vectors++;
        if (q !== 8'd142 || r !== 8'd6 || {dbz, ovf, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL normal_result: got q=%0d r=%0d flags=%b%b%b want 142 6 000",
                     q, r, dbz, ovf, err);
        end
        run_req(16'h07FF, 8'h08, lat, starts, slat, got, q, r, dbz, ovf, err);
        vectors++;
        if (lat !== 22 || q !== 8'hFF || r !== 8'd7 || {dbz, ovf} !== 2'b00) begin
            miscompares++;
            $display("FAIL edge_07ff: got lat=%0d q=%h r=%0d dbz=%b ovf=%b want 22 ff 7 0 0",
                     lat, q, r, dbz, ovf);
        end
    endtask

    task automatic test_dbz;
        int lat, starts, slat;
        logic got, dbz, ovf, err;
        logic [7:0] q, r;
        run_req(16'h1234, 8'd0, lat, starts, slat, got, q, r, dbz, ovf, err);
        vectors++;
        if (lat !== 2 || starts !== 0) begin
            miscompares++;
            $display("FAIL dbz_timing: got lat=%0d starts=%0d want 2 0", lat, starts);
        end
        vectors++;
        if (q !== 8'hFF || r !== 8'h00 || {dbz, ovf, err} !== 3'b100) begin
            miscompares++;
            $display("FAIL dbz_result: got q=%h r=%h flags=%b%b%b want ff 00 100",
                     q, r, dbz, ovf, err);
        end
    endtask

    task automatic test_ovf;
        int lat, starts, slat;
        logic got, dbz, ovf, err;
        logic [7:0] q, r;
        run_req(16'h0800, 8'h08, lat, starts, slat, got, q, r, dbz, ovf, err);
        vectors++;
        if (lat !== 2 || starts !== 0) begin
            miscompares++;
            $display("FAIL ovf_timing: got lat=%0d starts=%0d want 2 0", lat, starts);
        end
        vectors++;
        if (q !== 8'hFF || r !== 8'h00 || {dbz, ovf, err} !== 3'b010) begin
            miscompares++;
            $display("FAIL ovf_result: got q=%h r=%h flags=%b%b%b want ff 00 010",
                     q, r, dbz, ovf, err);
        end
    endtask

    task automatic test_backpressure;
        int guard;
        req_dividend = 16'd1000;
        req_divisor  = 8'd7;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 200) begin @(posedge clk); #1; guard++; end
        // Offer a second request while the response is stalled.
        req_dividend = 16'd100;
        req_divisor  = 8'd3;
        req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_quotient !== 8'd142 || rsp_remainder !== 8'd6 ||
                req_ready !== 1'b0 || div_dividend !== 16'd1000) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b q=%0d r=%0d rdy=%b dd=%0d want 1 142 6 0 1000",
                         i, rsp_valid, rsp_quotient, rsp_remainder, req_ready, div_dividend);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++;
        if (div_dividend !== 16'd100 || div_divisor !== 8'd3) begin
            miscompares++;
            $display("FAIL bp_accept: got dd=%0d dv=%0d want 100 3", div_dividend, div_divisor);
        end
        guard = 0;
        while (!rsp_valid && guard < 200) begin @(posedge clk); #1; guard++; end
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_quotient !== 8'd33 || rsp_remainder !== 8'd1) begin
            miscompares++;
            $display("FAIL bp_second: got v=%b q=%0d r=%0d want 1 33 1",
                     rsp_valid, rsp_quotient, rsp_remainder);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        int lat, starts, slat, seen;
        logic got, dbz, ovf, err;
        logic [7:0] q, r;
        req_dividend = 16'd2000;
        req_divisor  = 8'd9;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors++;
        if ({div_start, div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_remainder,
             rsp_dbz, rsp_ovf, rsp_err} !== 44'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got start=%b dd=%h dv=%h v=%b q=%h r=%h want all 0",
                     div_start, div_dividend, div_divisor, rsp_valid, rsp_quotient,
                     rsp_remainder);
        end
        @(posedge clk); #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ready: got %b want 1", req_ready);
        end
        seen = 0;
        repeat (30) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL midreset_no_rsp: got %0d valid cycles want 0", seen);
        end
        run_req(16'd255, 8'd16, lat, starts, slat, got, q, r, dbz, ovf, err);
        vectors++;
        if (lat !== 22 || q !== 8'd15 || r !== 8'd15) begin
            miscompares++;
            $display("FAIL midreset_next: got lat=%0d q=%0d r=%0d want 22 15 15", lat, q, r);
        end
    endtask

    task automatic test_random;
        int lat, starts, slat, elat;
        logic got, dbz, ovf, err, edbz, eovf;
        logic [7:0] q, r, eq, er, dv;
        logic [15:0] dd;
        for (int n = 0; n < 24; n++) begin
            dd = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       dv = 8'd0;
                1:       dv = 8'($urandom_range(1, 15));
                default: dv = 8'($urandom_range(1, 255));
            endcase
            ref_model(dd, dv, elat, eq, er, edbz, eovf);
            run_req(dd, dv, lat, starts, slat, got, q, r, dbz, ovf, err);
            vectors++;
            if (lat !== elat || q !== eq || r !== er || dbz !== edbz || ovf !== eovf ||
                err !== 1'b0 || starts !== ((elat == 22) ? 1 : 0)) begin
                miscompares++;
                $display("FAIL random[%0d] %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b ovf=%b err=%b starts=%0d want %0d %0d %0d %b %b 0 %0d",
                         n, dd, dv, lat, q, r, dbz, ovf, err, starts, elat, eq, er, edbz,
                         eovf, (elat == 22) ? 1 : 0);
            end
        end
    endtask

    task automatic test_timeout;
        int lat, starts, slat;
        logic got, dbz, ovf, err;
        logic [7:0] q, r;
        done_en = 1'b0;
        run_req(16'd1000, 8'd7, lat, starts, slat, got, q, r, dbz, ovf, err);
`ifdef DIV_TIMEOUT_EN
        // WAIT entered at accept+3; response 33 cycles later.
        vectors++;
        if (got !== 1'b1 || lat !== 36) begin
            miscompares++;
            $display("FAIL timeout_latency: got valid=%b lat=%0d want 1 36", got, lat);
        end
        vectors++;
        if (err !== 1'b1 || q !== 8'hFF || r !== 8'h00 || {dbz, ovf} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_result: got err=%b q=%h r=%h dbz=%b ovf=%b want 1 ff 00 0 0",
                     err, q, r, dbz, ovf);
        end
`else
        vectors++;
        if (got !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout: got valid=%b err=%b want 0 0", got, err);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif
        done_en = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_recover: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_dividend = 16'd0;
        req_divisor  = 8'd0;
        rsp_ready    = 1'b0;
        test_reset();
        test_normal();
        test_dbz();
        test_ovf();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
